// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control path: FSM state encodings,
// instr[6:4] instruction class codes, ALU operation codes and the control
// strobe bundle. Also used by the immediate generator and ALU control.
package multicycle_ctrl_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned ALUOP_W   = 2;
  localparam int unsigned OPCLASS_W = 3;
  localparam int unsigned INSTRET_W = 64;

  // Bit positions inside the instruction word
  localparam int unsigned OPC_LO  = 4;
  localparam int unsigned OPC_HI  = 6;
  localparam int unsigned BNE_BIT = 12;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [OPCLASS_W-1:0] {
    CLS_LOAD   = 3'b000,
    CLS_IALU   = 3'b001,
    CLS_STORE  = 3'b010,
    CLS_RALU   = 3'b011,
    CLS_BRANCH = 3'b110
  } opclass_t;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // Datapath control strobes driven by the FSM each cycle
  typedef struct packed {
    logic               imem_req;
    logic               ir_we;
    logic               pc_we;
    logic               pc_sel;
    logic               reg_we;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src;
    logic               mem_to_reg;
    logic [ALUOP_W-1:0] alu_op;
    logic               retire;
  } ctrl_t;

  // Classes whose second ALU operand is the immediate
  function automatic logic uses_imm(input opclass_t cls);
    return (cls == CLS_IALU) || (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

  // ALU operation selected during EXEC
  function automatic logic [ALUOP_W-1:0] exec_alu_op(input opclass_t cls);
    logic [ALUOP_W-1:0] op;
    op = ALUOP_ADD;
    case (cls)
      CLS_RALU, CLS_IALU: op = ALUOP_FUNCT;
      CLS_BRANCH:         op = ALUOP_SUB;
      default:            op = ALUOP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/opclass_dec.sv
// Combinational instruction class decoder.
// Ports: op  - instr[6:4] field
//        cls - decoded class (R-ALU when op is not a supported class)
//        valid - op is a supported class
module opclass_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPCLASS_W-1:0] op,
  output opclass_t             cls,
  output logic                 valid
);

  // Map the supported codes; anything else is flagged invalid
  always_comb begin
    cls   = CLS_RALU;
    valid = 1'b1;
    case (op)
      3'b011:  cls = CLS_RALU;
      3'b001:  cls = CLS_IALU;
      3'b000:  cls = CLS_LOAD;
      3'b010:  cls = CLS_STORE;
      3'b110:  cls = CLS_BRANCH;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB],
// with an absorbing TRAP state for unsupported instruction classes.
// Ports: clk, rst (async active-high); instr (from external IR), imem_ack,
//        dmem_ack, zero in; datapath strobes imem_req, ir_we, pc_we, pc_sel,
//        reg_we, mem_rd, mem_wr, alu_src, mem_to_reg, alu_op out; state,
//        illegal (sticky), retire (one pulse per completed instruction).
// Build option: INSTRET_CNT_EN adds a 64-bit retired-instruction counter
//        output, instret.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  input  logic                 zero,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 reg_we,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic [ALUOP_W-1:0]   alu_op,
  output logic [STATE_W-1:0]   state,
  output logic                 illegal,
`ifdef INSTRET_CNT_EN
  output logic [INSTRET_W-1:0] instret,
`endif
  output logic                 retire
);

  state_t   state_q, state_d;
  opclass_t cls_q;
  opclass_t dec_cls;
  logic     dec_valid;
  logic     illegal_q;
  logic     taken;
  ctrl_t    ctrl_c;
  ctrl_t    ctrl;

  // Only opcode class and the beq/bne select bit are used here
  logic unused_instr;
  assign unused_instr = ^{instr[INSTR_W-1:BNE_BIT+1], instr[BNE_BIT-1:OPC_HI+1],
                          instr[OPC_LO-1:0]};

  opclass_dec u_opclass_dec (
    .op    (instr[OPC_HI:OPC_LO]),
    .cls   (dec_cls),
    .valid (dec_valid)
  );

  // beq when instr[12]=0, bne when instr[12]=1
  assign taken = zero ^ instr[BNE_BIT];

  // State, registered class and sticky illegal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_RALU;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE && dec_valid) begin
        cls_q <= dec_cls;
      end
      if (state_d == ST_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next state and strobes; ir_we, MEM-exit pc_we/retire are Mealy on acks
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.imem_req = 1'b1;
        if (imem_ack) begin
          ctrl_c.ir_we = 1'b1;
          state_d      = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = dec_valid ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        ctrl_c.alu_src = uses_imm(cls_q);
        ctrl_c.alu_op  = exec_alu_op(cls_q);
        case (cls_q)
          CLS_RALU, CLS_IALU:  state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.pc_sel = taken;
            ctrl_c.retire = 1'b1;
            state_d       = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (cls_q == CLS_LOAD) begin
          ctrl_c.mem_rd = 1'b1;
          if (dmem_ack) begin
            state_d = ST_WB;
          end
        end else begin
          ctrl_c.mem_wr = 1'b1;
          if (dmem_ack) begin
            ctrl_c.pc_we  = 1'b1;
            ctrl_c.retire = 1'b1;
            state_d       = ST_FETCH;
          end
        end
      end
      ST_WB: begin
        ctrl_c.reg_we     = 1'b1;
        ctrl_c.pc_we      = 1'b1;
        ctrl_c.retire     = 1'b1;
        ctrl_c.mem_to_reg = (cls_q == CLS_LOAD);
        state_d           = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Reset kills every strobe immediately, including any outstanding request
  assign ctrl = rst ? '0 : ctrl_c;

  assign imem_req   = ctrl.imem_req;
  assign ir_we      = ctrl.ir_we;
  assign pc_we      = ctrl.pc_we;
  assign pc_sel     = ctrl.pc_sel;
  assign reg_we     = ctrl.reg_we;
  assign mem_rd     = ctrl.mem_rd;
  assign mem_wr     = ctrl.mem_wr;
  assign alu_src    = ctrl.alu_src;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_op     = ctrl.alu_op;
  assign retire     = ctrl.retire;
  assign state      = STATE_W'(state_q);
  assign illegal    = illegal_q;

`ifdef INSTRET_CNT_EN
  logic [INSTRET_W-1:0] instret_q;

  // Retired-instruction counter; wraps naturally at 2^64
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (ctrl.retire) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign instret = instret_q;
`endif

endmodule
